// File: rtl/axis_sample_packer.sv
// Sample FIFO plus byte serializer that frames I/Q sample words into fixed-size AXI-Stream packets.
// Define PACKER_HEADER_EN to prefix every packet with 8'hA5 and an 8-bit sequence number.
module axis_sample_packer #(
  parameter int ANTENNAS       = 24,
  parameter int ABITS          = 4,
  parameter int PACKET_SAMPLES = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable_i,
  input  logic                smp_valid_i,
  input  logic [ANTENNAS-1:0] smp_i_i,
  input  logic [ANTENNAS-1:0] smp_q_i,
  output logic                overflow_o,
  output logic [15:0]         drop_count_o,
  output logic                m_axis_tvalid_o,
  input  logic                m_axis_tready_i,
  output logic                m_axis_tlast_o,
  output logic [7:0]          m_axis_tdata_o
);
  localparam int W      = 2 * ANTENNAS;
  localparam int B      = W / 8;
  localparam int DEPTH  = 1 << ABITS;
  localparam int IDX_W  = (B > 1) ? $clog2(B) : 1;
  localparam int SIDX_W = (PACKET_SAMPLES > 1) ? $clog2(PACKET_SAMPLES) : 1;
  localparam logic [ABITS:0]    FULL_CNT = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0]    PKT_CNT  = (ABITS+1)'(PACKET_SAMPLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(B - 1);
  localparam logic [SIDX_W-1:0] LAST_SMP = SIDX_W'(PACKET_SAMPLES - 1);

`ifdef PACKER_HEADER_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA} state_t;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [SIDX_W-1:0]   smp_reg, smp_next;
  logic [ABITS-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [ABITS-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [ABITS:0]      count_reg, count_next;
  logic                enable_q_reg;
  logic                overflow_reg, overflow_next;
  logic [15:0]         drop_reg, drop_next;
  logic                tvalid_reg;
  logic [7:0]          tdata_reg, tdata_next;
  logic                tlast_reg, tlast_next;
  logic [7:0]          seq_reg, seq_next;

  logic hs, full, wr_en, drop, flush, rise, pop, pkt_done;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] head_word;
  logic [7:0]   head_bytes [B];

  assign hs    = tvalid_reg & m_axis_tready_i;
  assign full  = (count_reg == FULL_CNT);
  assign wr_en = smp_valid_i & enable_i & ~full;
  assign drop  = smp_valid_i & enable_i & full;
  assign flush = (state_reg == S_IDLE) & ~enable_i;
  assign rise  = enable_i & ~enable_q_reg;

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_reg] <= {smp_q_i, smp_i_i};
  end

  // Look ahead to the head the FSM will present after this edge so tdata can be registered.
  assign head_word = mem[rd_ptr_next];
  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_bytes
      assign head_bytes[gi] = head_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    smp_next   = smp_reg;
    pop        = 1'b0;
    pkt_done   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable_i && count_reg >= PKT_CNT) begin
`ifdef PACKER_HEADER_EN
          state_next = S_HDR0;
`else
          state_next = S_DATA;
`endif
          idx_next = '0;
          smp_next = '0;
        end
      end
`ifdef PACKER_HEADER_EN
      S_HDR0: if (hs) state_next = S_HDR1;
      S_HDR1: if (hs) state_next = S_DATA;
`endif
      S_DATA: begin
        if (hs) begin
          if (idx_reg == LAST_IDX) begin
            pop      = 1'b1;
            idx_next = '0;
            if (smp_reg == LAST_SMP) begin
              state_next = S_IDLE;
              pkt_done   = 1'b1;
            end else begin
              smp_next = smp_reg + 1'b1;
            end
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ptr_next = rd_ptr_reg + ABITS'(pop);
    wr_ptr_next = wr_ptr_reg + ABITS'(wr_en);
    count_next  = count_reg + (ABITS+1)'(wr_en) - (ABITS+1)'(pop);
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_comb begin
    overflow_next = overflow_reg | drop;
    drop_next     = drop_reg;
    if (drop && drop_reg != 16'hFFFF) drop_next = drop_reg + 16'd1;
    if (rise) begin
      overflow_next = drop;
      drop_next     = {15'd0, drop};
    end
  end

  always_comb begin
    seq_next = seq_reg;
`ifdef PACKER_HEADER_EN
    if (pkt_done) seq_next = seq_reg + 8'd1;
    if (rise) seq_next = 8'd0;
`endif
  end

  // A stalled beat keeps its byte; otherwise load what the next state presents.
  always_comb begin
    tdata_next = tdata_reg;
    tlast_next = tlast_reg;
    if (!tvalid_reg || m_axis_tready_i) begin
      tdata_next = 8'h00;
      tlast_next = 1'b0;
      case (state_next)
        S_DATA: begin
          tdata_next = head_bytes[idx_next];
          tlast_next = (idx_next == LAST_IDX) && (smp_next == LAST_SMP);
        end
`ifdef PACKER_HEADER_EN
        S_HDR0: tdata_next = 8'hA5;
        S_HDR1: tdata_next = seq_next;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      smp_reg      <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      enable_q_reg <= 1'b0;
      overflow_reg <= 1'b0;
      drop_reg     <= '0;
      tvalid_reg   <= 1'b0;
      tdata_reg    <= '0;
      tlast_reg    <= 1'b0;
      seq_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      smp_reg      <= smp_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      enable_q_reg <= enable_i;
      overflow_reg <= overflow_next;
      drop_reg     <= drop_next;
      tvalid_reg   <= (state_next != S_IDLE);
      tdata_reg    <= tdata_next;
      tlast_reg    <= tlast_next;
      seq_reg      <= seq_next;
    end
  end

  assign overflow_o      = overflow_reg;
  assign drop_count_o    = drop_reg;
  assign m_axis_tvalid_o = tvalid_reg;
  assign m_axis_tlast_o  = tlast_reg;
  assign m_axis_tdata_o  = tdata_reg;

endmodule

// File: tb/tb_axis_sample_packer.sv
// Randomized and directed bench for axis_sample_packer against a queue-based packet model.
// Honours PACKER_HEADER_EN when the design is built with it.
`timescale 1ns/1ps
module tb_axis_sample_packer;
  localparam int ANTENNAS = 24;
  localparam int ABITS    = 4;
  localparam int PS       = 4;
  localparam int W        = 2 * ANTENNAS;
  localparam int B        = W / 8;
  localparam int DEPTH    = 1 << ABITS;
`ifdef PACKER_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif
  localparam int PLEN = HDR + PS * B;

  logic                aclk = 1'b0;
  logic                aresetn, enable_i, smp_valid_i, m_axis_tready_i;
  logic [ANTENNAS-1:0] smp_i_i, smp_q_i;
  logic                overflow_o, m_axis_tvalid_o, m_axis_tlast_o;
  logic [15:0]         drop_count_o;
  logic [7:0]          m_axis_tdata_o;

  int checks = 0;
  int errors = 0;

  axis_sample_packer #(.ANTENNAS(ANTENNAS), .ABITS(ABITS), .PACKET_SAMPLES(PS)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable_i(enable_i), .smp_valid_i(smp_valid_i),
    .smp_i_i(smp_i_i), .smp_q_i(smp_q_i), .overflow_o(overflow_o), .drop_count_o(drop_count_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tlast_o(m_axis_tlast_o), .m_axis_tdata_o(m_axis_tdata_o)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_fifo[$];
  logic [7:0]   m_bytes[$];
  int           m_pos;
  bit           m_busy, m_valid, m_last, m_ovf, m_en_q;
  logic [7:0]   m_data, m_seq;
  logic [15:0]  m_drops;

  initial begin
    bit hs, rise, was_busy, full, wr, drp;
    logic [W-1:0] t;
    m_busy = 0; m_pos = 0; m_valid = 0; m_last = 0; m_data = 0;
    m_ovf = 0; m_en_q = 0; m_seq = 0; m_drops = 0;
    forever begin
      @(posedge aclk);
      if (!aresetn) begin
        m_fifo.delete(); m_bytes.delete();
        m_busy = 0; m_pos = 0; m_ovf = 0; m_en_q = 0; m_seq = 0; m_drops = 0;
      end else begin
        hs       = m_valid && m_axis_tready_i;
        rise     = enable_i && !m_en_q;
        was_busy = m_busy;
        full     = (m_fifo.size() == DEPTH);
        wr       = smp_valid_i && enable_i && !full;
        drp      = smp_valid_i && enable_i && full;
        if (hs) begin
          if (m_pos >= HDR && (m_pos - HDR) % B == B - 1) void'(m_fifo.pop_front());
          m_pos++;
          if (m_pos == PLEN) begin
            m_busy = 0;
            m_seq  = m_seq + 8'd1;
          end
        end
        if (rise) begin
          m_drops = {15'd0, drp};
          m_ovf   = drp;
          m_seq   = 8'd0;
        end else if (drp) begin
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
          m_ovf = 1;
        end
        if (!was_busy) begin
          if (!enable_i) m_fifo.delete();
          else if (m_fifo.size() >= PS) begin
            m_bytes.delete();
            if (HDR == 2) begin
              m_bytes.push_back(8'hA5);
              m_bytes.push_back(m_seq);
            end
            for (int s = 0; s < PS; s++)
              for (int b = 0; b < B; b++) begin
                t = m_fifo[s] >> (8 * b);
                m_bytes.push_back(t[7:0]);
              end
            m_busy = 1;
            m_pos  = 0;
          end
        end
        if (wr) m_fifo.push_back({smp_q_i, smp_i_i});
        m_en_q = enable_i;
      end
      m_valid = m_busy;
      m_data  = m_busy ? m_bytes[m_pos] : 8'h00;
      m_last  = m_busy && (m_pos == PLEN - 1);
    end
  end

  // ---------------- per-cycle compare and capture ----------------
  logic [7:0] cap_d[$];
  bit         cap_l[$];
  int         tv_cycles = 0;

  initial begin
    logic pv, pr, pl;
    logic [7:0] pd;
    pv = 0; pr = 0; pl = 0; pd = 0;
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      check("tvalid", m_axis_tvalid_o, m_valid);
      if (m_valid) begin
        check("tdata", m_axis_tdata_o, m_data);
        check("tlast", m_axis_tlast_o, m_last);
      end
      check("overflow", overflow_o, m_ovf);
      check("drop_count", drop_count_o, m_drops);
      if (pv && !pr && m_valid) begin
        check("stall_tdata", m_axis_tdata_o, pd);
        check("stall_tlast", m_axis_tlast_o, pl);
      end
      if (m_axis_tvalid_o) tv_cycles++;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        cap_d.push_back(m_axis_tdata_o);
        cap_l.push_back(m_axis_tlast_o);
      end
      pv = m_axis_tvalid_o; pr = m_axis_tready_i; pd = m_axis_tdata_o; pl = m_axis_tlast_o;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic push(input logic [23:0] i, input logic [23:0] q);
    smp_valid_i = 1; smp_i_i = i; smp_q_i = q;
    step();
    smp_valid_i = 0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (cap_d.size() < n && c < budget) begin
      step();
      c++;
    end
    if (cap_d.size() < n) check("timeout_bytes", cap_d.size(), n);
  endtask

  function automatic int count_lasts();
    int n;
    n = 0;
    foreach (cap_l[k]) if (cap_l[k]) n++;
    return n;
  endfunction

  initial begin
    aresetn = 0; enable_i = 0; smp_valid_i = 0; m_axis_tready_i = 1;
    smp_i_i = '0; smp_q_i = '0;
    step(3);
    check("rst_tvalid", m_axis_tvalid_o, 0);
    check("rst_tlast", m_axis_tlast_o, 0);
    check("rst_tdata", m_axis_tdata_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_drops", drop_count_o, 0);
    aresetn = 1; enable_i = 1;
    step(2);

    // basic packet and start latency
    cap_d.delete(); cap_l.delete();
    for (int s = 0; s < PS; s++) push(24'h030201, 24'h060504);
    check("lat_n1_tvalid", m_axis_tvalid_o, 0);
    step();
    check("lat_n2_tvalid", m_axis_tvalid_o, 1);
    wait_bytes(PLEN, 100);
    check("basic_len", cap_d.size(), PLEN);
    for (int k = 0; k < PS * B; k++) begin
      check("basic_byte", cap_d[HDR + k], (k % 6) + 1);
      check("basic_last", cap_l[HDR + k], (k == PS * B - 1));
    end
    step(3);

    // backpressure
    cap_d.delete(); cap_l.delete();
    for (int s = 0; s < PS; s++) push(24'hCCBBAA, 24'h11FFEE);
    for (int c = 0; c < 200 && cap_d.size() < PLEN; c++) begin
      m_axis_tready_i = (c % 2 == 0);
      step();
    end
    m_axis_tready_i = 1;
    check("bp_len", cap_d.size(), PLEN);
    check("bp_byte0", cap_d[HDR], 8'hAA);
    check("bp_byte5", cap_d[HDR + 5], 8'h11);
    check("bp_byte_last", cap_d[PLEN - 1], 8'h11);
    check("bp_lasts", count_lasts(), 1);
    step(3);

    // overflow
    m_axis_tready_i = 0;
    for (int s = 0; s < 20; s++) push(24'($urandom), 24'($urandom));
    check("ovf_drops", drop_count_o, 4);
    check("ovf_flag", overflow_o, 1);
    cap_d.delete(); cap_l.delete();
    m_axis_tready_i = 1;
    wait_bytes(4 * PLEN, 600);
    step(10);
    check("ovf_bytes", cap_d.size(), 4 * PLEN);
    check("ovf_packets", count_lasts(), 4);
    enable_i = 0; step();
    enable_i = 1; step(2);
    check("ovf_clr_drops", drop_count_o, 0);
    check("ovf_clr_flag", overflow_o, 0);

    // enable drop mid-packet
    cap_d.delete(); cap_l.delete();
    for (int s = 0; s < 6; s++) push(24'($urandom), 24'($urandom));
    check("en_started", m_axis_tvalid_o, 1);
    enable_i = 0;
    wait_bytes(PLEN, 200);
    tv_cycles = 0;
    step(20);
    check("en_len", cap_d.size(), PLEN);
    check("en_no_tvalid", tv_cycles, 0);
    enable_i = 1;
    step(10);
    check("en_resid_gone", tv_cycles, 0);

    // reset mid-packet
    cap_d.delete(); cap_l.delete();
    for (int s = 0; s < PS; s++) push(24'($urandom), 24'($urandom));
    for (int c = 0; c < 100 && cap_d.size() < 10; c++) step();
    aresetn = 0;
    step();
    check("rstmid_tvalid", m_axis_tvalid_o, 0);
    check("rstmid_tlast", m_axis_tlast_o, 0);
    check("rstmid_tdata", m_axis_tdata_o, 0);
    aresetn = 1;
    step(2);
    cap_d.delete(); cap_l.delete();
    for (int s = 0; s < PS; s++) push(24'h030201, 24'h060504);
    wait_bytes(PLEN, 100);
    step(3);
    check("rstmid_len", cap_d.size(), PLEN);
    check("rstmid_first", cap_d[HDR], 8'h01);
    check("rstmid_lasts", count_lasts(), 1);

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      smp_valid_i     = ($urandom % 3 == 0);
      smp_i_i         = 24'($urandom);
      smp_q_i         = 24'($urandom);
      m_axis_tready_i = ($urandom % 4 != 0);
      if ($urandom % 150 == 0) enable_i = ~enable_i;
      step();
    end
    smp_valid_i = 0; enable_i = 1; m_axis_tready_i = 1;
    step(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_sample_packer.md
Name: axis_sample_packer

Overview:
- Acquisition-side packetizer feeding the USB bulk IN channel (the s_axis input of ulpi_bulk_axis).
- Captures latched I/Q antenna sample words and buffers them in a sample FIFO.
- Serializes each sample to bytes and frames fixed-size packets, driving tlast on each packet's final byte.
- Samples arriving while the FIFO is full are dropped and counted, because upstream capture cannot stall.

Parameters:
ANTENNAS, 24, bits per I word and per Q word; 2*ANTENNAS must be a multiple of 8
ABITS, 4, sample FIFO depth = 2**ABITS samples
PACKET_SAMPLES, 8, samples per packet; 1 <= PACKET_SAMPLES <= 2**ABITS

Ports:
aclk  in  1  system clock; all logic on rising edge
aresetn  in  1  reset, synchronous, active-low
enable_i  in  1  capture enable
smp_valid_i  in  1  one-cycle strobe: sample present on smp_i_i/smp_q_i (already in aclk domain)
smp_i_i  in  ANTENNAS  in-phase bits, one per antenna
smp_q_i  in  ANTENNAS  quadrature bits, one per antenna
overflow_o  out  1  sticky: at least one sample dropped
drop_count_o  out  16  dropped-sample count, saturating
m_axis_tvalid_o  out  1  AXI-Stream valid
m_axis_tready_i  in  1  AXI-Stream ready
m_axis_tlast_o  out  1  last byte of packet
m_axis_tdata_o  out  8  packet byte

Behaviour:
- Clock and reset: one clock, aclk. Reset aresetn is synchronous and active-low.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, byte index 0.
- Sample word: {smp_q_i, smp_i_i}, width W = 2*ANTENNAS.
  - Serialized as B = W/8 bytes, least-significant byte first.
  - With the default ANTENNAS=24: W = 48, B = 6.
- FIFO write:
  - Write when smp_valid_i=1 and enable_i=1 and registered count < 2**ABITS.
  - There is no full-bypass: the sample is dropped if count == 2**ABITS, even when a read occurs in the same cycle.
  - smp_valid_i with enable_i=0 is ignored; it is not counted as a drop.
- Drop:
  - drop_count_o increments and saturates at 16'hFFFF.
  - overflow_o is set one cycle after the dropped strobe.
  - Both clear only on reset or on the rising edge of enable_i.
- FIFO read: the head sample pops in the cycle its last byte is accepted (tvalid & tready). A simultaneous write and read leaves count unchanged.
- FSM states:
  - IDLE: tvalid=0.
    - Go to DATA when enable_i=1 and count >= PACKET_SAMPLES.
    - A packet starts only when it is fully buffered, so it never stalls mid-packet for lack of data.
  - DATA: tvalid=1, tdata = byte[idx] of the head sample.
    - On handshake, idx advances; it wraps from B-1 to 0 and the sample is popped.
    - tlast=1 on byte B-1 of sample PACKET_SAMPLES-1. A handshake on that byte returns the FSM to IDLE.
- Latency: a write that makes count reach PACKET_SAMPLES at edge N gives count valid at N+1, FSM in DATA at N+2, and tvalid high in cycle N+2.
- Back-to-back packets: the FSM passes through IDLE for one cycle between packets, so tvalid drops for exactly one cycle.
- AXI-Stream rules:
  - tdata, tlast and tvalid are registered.
  - Once tvalid=1, tdata and tlast hold stable until the handshake.
  - tvalid never drops without a handshake.
- enable_i=0:
  - No new writes and no new packet starts.
  - A packet in progress completes normally.
  - While the FSM is IDLE, the FIFO is held empty, so residual samples are discarded.
- Reset mid-packet: the packet is abandoned immediately; tvalid=0 in the cycle after aresetn is sampled low.

Optional Feature:
- Macro: PACKER_HEADER_EN.
- Defined: each packet is prefixed by two header bytes, inserted by states HDR0 and HDR1 between IDLE and DATA.
  - HDR0 sends 8'hA5; HDR1 sends the 8-bit sequence number.
  - The sequence number increments after each completed packet and wraps 255 -> 0.
  - It is reset to 0 by reset and by the rising edge of enable_i.
  - Packet length = 2 + PACKET_SAMPLES*B bytes. tlast placement is unchanged.
- Undefined: no header states; packet length = PACKET_SAMPLES*B bytes.

Test Plan:
- Test configuration: ANTENNAS=24, ABITS=4, PACKET_SAMPLES=4, tready held 1, header off.
- Basic packet: write 4 samples with I=24'h030201, Q=24'h060504 -> 24 bytes; each 6-byte group is 01 02 03 04 05 06; tlast only on byte 24; first tvalid 2 cycles after the 4th write.
- Backpressure: toggle tready 1-0-1-0 -> byte order identical, tdata/tlast stable while tvalid=1 and tready=0, no bytes lost or duplicated.
- Overflow: tready=0, write 20 samples -> 16 stored, drop_count_o=4, overflow_o=1; then tready=1 -> exactly 4 packets. Pulse enable 0->1 -> drop_count_o=0, overflow_o=0.
- Enable drop: write 6 samples, deassert enable_i after the first packet has started -> that packet completes (24 bytes), remaining 2 samples are discarded, no further tvalid.
- Header (PACKER_HEADER_EN): 3 packets -> each starts A5 then 00, 01, 02; length 26 bytes each.
- Reset mid-packet: assert aresetn=0 at byte 10 -> tvalid=0 next cycle, outputs 0; after release, 4 new samples -> a clean 24-byte packet.
